// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential multiplier and the shared ALU it drives:
// ALU operation encodings and the multiplier FSM state type.
package mul_seq_pkg;

  localparam int unsigned DEF_N = 64;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_TEST = 2'b01,
    ST_STEP = 2'b10,
    ST_DONE = 2'b11
  } mul_state_t;

endpackage

// File: rtl/mul_seq_if.sv
// Request/result bus of mul_seq plus its borrowed ALU port; slave is the
// multiplier side, master is the requester/ALU side.
interface mul_seq_if #(parameter int unsigned N = 64);

  logic         start;
  logic [N-1:0] multiplicand;
  logic [N-1:0] multiplier;
  logic         busy;
  logic         done;
  logic [N-1:0] product;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_ctrl;
  logic [N-1:0] alu_result;
  logic         alu_zero;

  modport slave (
    input  start, multiplicand, multiplier, alu_result, alu_zero,
    output busy, done, product, alu_a, alu_b, alu_ctrl
  );

  modport master (
    output start, multiplicand, multiplier, alu_result, alu_zero,
    input  busy, done, product, alu_a, alu_b, alu_ctrl
  );

endinterface

// File: rtl/alu.sv
// Shared combinational ALU; mul_seq borrows it through alu_a/alu_b/alu_ctrl.
module alu
  import mul_seq_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ctrl,
  output logic [N-1:0] result,
  output logic         zero
);

  // operation decode; unknown encodings yield zero
  always_comb begin
    result = {N{1'b0}};
    case (ctrl)
      ALU_AND:   result = a & b;
      ALU_ORR:   result = a | b;
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_PASSB: result = b;
      ALU_NOR:   result = ~(a | b);
      default:   result = {N{1'b0}};
    endcase
  end

  assign zero = (result == {N{1'b0}});

endmodule

// File: rtl/mul_seq.sv
// Shift-and-add multiplier that borrows an external ALU: TEST checks for a
// remaining multiplier bit via ORR, STEP accumulates via ADD.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int unsigned N = DEF_N
) (
  input  logic       clk,
  input  logic       reset_n,
  mul_seq_if.slave   bus
);

  mul_state_t   state_r;
  logic [N-1:0] mcand_r;
  logic [N-1:0] mplier_r;
  logic [N-1:0] acc_r;
  logic [N-1:0] product_r;
  logic         busy_r;
  logic         done_r;
  logic [N-1:0] alu_a_s;
  logic [N-1:0] alu_b_s;
  logic [3:0]   alu_ctrl_s;

  // ALU operand steering from current state and registers
  always_comb begin
    alu_a_s    = {N{1'b0}};
    alu_b_s    = {N{1'b0}};
    alu_ctrl_s = 4'b0000;
    case (state_r)
      ST_TEST: begin
        alu_a_s    = mplier_r;
        alu_b_s    = {N{1'b0}};
        alu_ctrl_s = ALU_ORR;
      end
      ST_STEP: begin
        alu_a_s    = acc_r;
        alu_b_s    = mplier_r[0] ? mcand_r : {N{1'b0}};
        alu_ctrl_s = ALU_ADD;
      end
      default: begin
        alu_a_s    = {N{1'b0}};
        alu_b_s    = {N{1'b0}};
        alu_ctrl_s = 4'b0000;
      end
    endcase
  end

  // FSM, datapath registers and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      mcand_r   <= {N{1'b0}};
      mplier_r  <= {N{1'b0}};
      acc_r     <= {N{1'b0}};
      product_r <= {N{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            mcand_r  <= bus.multiplicand;
            mplier_r <= bus.multiplier;
            acc_r    <= {N{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= ST_TEST;
          end else begin
            busy_r   <= 1'b0;
          end
        end
        ST_TEST: begin
          // ORR with zero leaves alu_zero high once no multiplier bits remain
          if (bus.alu_zero) begin
            product_r <= acc_r;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            busy_r    <= 1'b1;
            state_r   <= ST_STEP;
          end
        end
        ST_STEP: begin
          acc_r    <= bus.alu_result;
          mcand_r  <= {mcand_r[N-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[N-1:1]};
          busy_r   <= 1'b1;
          state_r  <= ST_TEST;
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.product  = product_r;
  assign bus.alu_a    = alu_a_s;
  assign bus.alu_b    = alu_b_s;
  assign bus.alu_ctrl = alu_ctrl_s;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq wired to the shared alu: products, latency,
// busy width, ALU op legality, ignored restarts and asynchronous reset.
module tb_mul_seq;
  import mul_seq_pkg::*;

  localparam int unsigned N = 64;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  mul_seq_if #(.N(N)) bus ();

  mul_seq #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  alu #(.N(N)) u_alu (
    .a      (bus.alu_a),
    .b      (bus.alu_b),
    .ctrl   (bus.alu_ctrl),
    .result (bus.alu_result),
    .zero   (bus.alu_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [63:0] b);
    int l;
    l = 0;
    for (int i = 0; i < 64; i++) begin
      if (b[i]) l = i + 1;
    end
    return 2 * l + 2;
  endfunction

  // Issue one multiply from a negedge; optionally re-assert start (with other
  // operands) at cycle poke, which must be ignored.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input int poke, input logic [63:0] exp_p, input int exp_lat);
    int   lat;
    int   busy_n;
    logic ctrl_bad;
    logic [3:0] first_ctrl;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    lat        = 1;
    busy_n     = 0;
    ctrl_bad   = 1'b0;
    first_ctrl = bus.alu_ctrl;
    while (!bus.done && lat < 300) begin
      if (bus.busy) begin
        busy_n++;
        if (bus.alu_ctrl != ALU_ORR && bus.alu_ctrl != ALU_ADD) ctrl_bad = 1'b1;
      end
      if (lat == poke) begin
        bus.start        = 1'b1;
        bus.multiplicand = 64'd2;
        bus.multiplier   = 64'd2;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check({tag, ".done_seen"}, {63'd0, bus.done}, 64'd1);
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".product"}, bus.product, exp_p);
    check({tag, ".busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
    check({tag, ".first_ctrl"}, {60'd0, first_ctrl}, {60'd0, ALU_ORR});
    check({tag, ".ctrl_legal"}, {63'd0, ctrl_bad}, 64'd0);
    @(negedge clk);
    check({tag, ".done_pulse"}, {63'd0, bus.done}, 64'd0);
    check({tag, ".idle_busy"}, {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    int          extra_done;
    clk              = 1'b0;
    reset_n          = 1'b0;
    n_checks         = 0;
    n_errors         = 0;
    bus.start        = 1'b0;
    bus.multiplicand = 64'd0;
    bus.multiplier   = 64'd0;

    repeat (2) @(negedge clk);
    check("rst.busy", {63'd0, bus.busy}, 64'd0);
    check("rst.done", {63'd0, bus.done}, 64'd0);
    check("rst.product", bus.product, 64'd0);
    check("rst.alu_ctrl", {60'd0, bus.alu_ctrl}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle.alu_a", bus.alu_a, 64'd0);
    check("idle.alu_b", bus.alu_b, 64'd0);

    run_op("m3x5", 64'd3, 64'd5, -1, 64'd15, 8);
    run_op("mdeadx0", 64'hDEAD, 64'd0, -1, 64'd0, 2);
    run_op("mffx2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, -1, 64'hFFFF_FFFF_FFFF_FFFE, 6);
    run_op("m1xmsb", 64'd1, 64'h8000_0000_0000_0000, -1, 64'h8000_0000_0000_0000, 130);
    run_op("mffxff", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, -1, 64'd1, 130);
    run_op("m100x255", 64'd100, 64'd255, -1, 64'd25500, 18);
    run_op("m1234x10", 64'h1234, 64'h10, -1, 64'h12340, 12);

    // restart attempt during STEP (cycle 2) must be ignored
    run_op("m7x9poke", 64'd7, 64'd9, 2, 64'd63, 10);
    extra_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    check("m7x9poke.extra_done", 64'(extra_done), 64'd0);

    // asynchronous reset in the middle of a STEP cycle
    bus.multiplicand = 64'd7;
    bus.multiplier   = 64'd9;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("areset.in_step", {60'd0, bus.alu_ctrl}, {60'd0, ALU_ADD});
    #1 reset_n = 1'b0;
    #1;
    check("areset.busy", {63'd0, bus.busy}, 64'd0);
    check("areset.done", {63'd0, bus.done}, 64'd0);
    check("areset.product", bus.product, 64'd0);
    check("areset.alu_a", bus.alu_a, 64'd0);
    check("areset.alu_b", bus.alu_b, 64'd0);
    check("areset.alu_ctrl", {60'd0, bus.alu_ctrl}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    extra_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra_done++;
    end
    check("areset.abandoned", 64'(extra_done), 64'd0);
    run_op("m4x4", 64'd4, 64'd4, -1, 64'd16, 8);

    // operand sweep against a*b mod 2^64
    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      run_op($sformatf("sweep%0d", i), ra, rb, -1, ra * rb, exp_latency(rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
